// File: rtl/mac_lane_array.sv
// Multi-lane fixed-point MAC neuron engine.
// LANES neurons share one activation stream; each lane keeps a guarded
// full-precision accumulator preloaded with a bias. Results are rounded half up
// and saturated back to Q(INT_BITS.FRC_BITS).
// Optional build macro: MAC_LANE_RELU_EN applies a ReLU after saturation.
module mac_lane_array #(
    parameter int unsigned INT_BITS   = 5,
    parameter int unsigned FRC_BITS   = 7,
    parameter int unsigned LANES      = 4,
    parameter int unsigned GUARD_BITS = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  n_inputs,
    input  logic [LANES*(INT_BITS+FRC_BITS)-1:0] bias,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [INT_BITS+FRC_BITS-1:0]      s_din,
    input  logic [LANES*(INT_BITS+FRC_BITS)-1:0] s_w,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [LANES*(INT_BITS+FRC_BITS)-1:0] m_dout,
    output logic [LANES-1:0]                  m_ovf,
    output logic                              busy
);

    localparam int unsigned W     = INT_BITS + FRC_BITS;
    localparam int unsigned P     = 2 * W;
    localparam int unsigned ACC_W = P + GUARD_BITS;
    localparam int unsigned RW    = ACC_W + 1;
    localparam int unsigned SW    = RW - FRC_BITS;

    localparam logic signed [RW-1:0] HALF = RW'(1) << (FRC_BITS - 1);
    localparam logic signed [SW-1:0] SMAX = SW'((2 ** (W - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t                   state_q;
    logic                     s_ready_q;
    logic                     m_valid_q;
    logic                     busy_q;
    logic [LANES*W-1:0]       m_dout_q;
    logic [LANES-1:0]         m_ovf_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         n_q;
    logic                     prod_vld_q;
    logic signed [ACC_W-1:0]  acc_q  [LANES];
    logic signed [P-1:0]      prod_q [LANES];

    logic signed [ACC_W-1:0]  acc_bias_c [LANES];
    logic signed [ACC_W-1:0]  acc_add_c  [LANES];
    logic signed [ACC_W-1:0]  src_c      [LANES];
    logic signed [RW-1:0]     rnd_c      [LANES];
    logic signed [SW-1:0]     sh_c       [LANES];
    logic [LANES*W-1:0]       res_c;
    logic [LANES-1:0]         ovf_c;
    logic                     xfer_c;
    logic                     last_c;

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_dout  = m_dout_q;
    assign m_ovf   = m_ovf_q;
    assign busy    = busy_q;

    assign xfer_c = s_valid && s_ready_q;
    assign last_c = (cnt_q == (n_q - CNT_W'(1)));

    // Bias preload, pending-product accumulation, then round/saturate per lane
    always_comb begin
        res_c = '0;
        ovf_c = '0;
        for (int k = 0; k < LANES; k++) begin
            acc_bias_c[k] = {{(ACC_W - W - FRC_BITS){bias[k*W + W - 1]}},
                             bias[k*W +: W], {FRC_BITS{1'b0}}};
            acc_add_c[k]  = prod_vld_q
                          ? acc_q[k] + {{GUARD_BITS{prod_q[k][P-1]}}, prod_q[k]}
                          : acc_q[k];
            src_c[k]      = (state_q == IDLE) ? acc_bias_c[k] : acc_add_c[k];
            rnd_c[k]      = {src_c[k][ACC_W-1], src_c[k]} + HALF;
            sh_c[k]       = SW'(rnd_c[k] >>> FRC_BITS);
            if (sh_c[k] > SMAX) begin
                res_c[k*W +: W] = {1'b0, {(W-1){1'b1}}};
                ovf_c[k]        = 1'b1;
            end else if (sh_c[k] < SMIN) begin
                res_c[k*W +: W] = {1'b1, {(W-1){1'b0}}};
                ovf_c[k]        = 1'b1;
            end else begin
                res_c[k*W +: W] = sh_c[k][W-1:0];
            end
`ifdef MAC_LANE_RELU_EN
            if (sh_c[k][SW-1]) begin
                res_c[k*W +: W] = '0;
                ovf_c[k]        = 1'b0;
            end
`endif
        end
    end

    // Control FSM, product pipeline, accumulators and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            m_dout_q   <= '0;
            m_ovf_q    <= '0;
            cnt_q      <= '0;
            n_q        <= '0;
            prod_vld_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k]  <= '0;
                prod_q[k] <= '0;
            end
        end else begin
            prod_vld_q <= xfer_c;
            if (xfer_c) begin
                for (int k = 0; k < LANES; k++) begin
                    prod_q[k] <= P'($signed(s_din)) * P'($signed(s_w[k*W +: W]));
                end
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < LANES; k++) acc_q[k] <= acc_bias_c[k];
                        cnt_q  <= '0;
                        n_q    <= n_inputs;
                        busy_q <= 1'b1;
                        if (n_inputs != '0) begin
                            state_q   <= ACC;
                            s_ready_q <= 1'b1;
                        end else begin
                            state_q   <= OUT;
                            m_valid_q <= 1'b1;
                            m_dout_q  <= res_c;
                            m_ovf_q   <= ovf_c;
                        end
                    end
                end
                ACC: begin
                    for (int k = 0; k < LANES; k++) acc_q[k] <= acc_add_c[k];
                    if (xfer_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_c) begin
                            state_q   <= DRAIN;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    for (int k = 0; k < LANES; k++) acc_q[k] <= acc_add_c[k];
                    state_q   <= OUT;
                    m_valid_q <= 1'b1;
                    m_dout_q  <= res_c;
                    m_ovf_q   <= ovf_c;
                end
                OUT: begin
                    if (m_ready) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_lane_array.sv
// Scoreboard bench for mac_lane_array: a driver issues passes and pushes the
// arithmetic reference result; a monitor compares whenever m_valid is high.
module tb_mac_lane_array;

    localparam int unsigned INT_BITS   = 5;
    localparam int unsigned FRC_BITS   = 7;
    localparam int unsigned LANES      = 4;
    localparam int unsigned GUARD_BITS = 4;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned W          = INT_BITS + FRC_BITS;
    localparam int unsigned ACC_W      = 2 * W + GUARD_BITS;
    localparam longint      MAXV       = (longint'(1) << (W - 1)) - 1;
    localparam longint      MINV       = -(longint'(1) << (W - 1));

    typedef struct packed {
        logic [LANES*W-1:0] d;
        logic [LANES-1:0]   o;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [CNT_W-1:0]     n_inputs;
    logic [LANES*W-1:0]   bias;
    logic                 s_valid;
    logic                 s_ready;
    logic [W-1:0]         s_din;
    logic [LANES*W-1:0]   s_w;
    logic                 m_valid;
    logic                 m_ready;
    logic [LANES*W-1:0]   m_dout;
    logic [LANES-1:0]     m_ovf;
    logic                 busy;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    int   xb [256];
    int   wb [256][LANES];
    int   bb [LANES];

    mac_lane_array #(
        .INT_BITS(INT_BITS), .FRC_BITS(FRC_BITS), .LANES(LANES),
        .GUARD_BITS(GUARD_BITS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_inputs(n_inputs), .bias(bias),
        .s_valid(s_valid), .s_ready(s_ready), .s_din(s_din), .s_w(s_w),
        .m_valid(m_valid), .m_ready(m_ready), .m_dout(m_dout), .m_ovf(m_ovf),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: exact integer dot product plus bias, wrapped to ACC_W,
    // then floor((acc + half) / 2^F) and clamp.
    function automatic exp_t model(input int n);
        exp_t   e;
        longint acc;
        longint r;
        longint md;
        e  = '0;
        md = longint'(1) << ACC_W;
        for (int k = 0; k < LANES; k++) begin
            acc = longint'(bb[k]) * (longint'(1) << FRC_BITS);
            for (int i = 0; i < n; i++) acc += longint'(xb[i]) * longint'(wb[i][k]);
            acc = acc % md;
            if (acc < 0) acc += md;
            if (acc >= md / 2) acc -= md;
            r = (acc + (longint'(1) << (FRC_BITS - 1))) >>> FRC_BITS;
            if (r > MAXV) begin
                r = MAXV;
                e.o[k] = 1'b1;
            end else if (r < MINV) begin
                r = MINV;
                e.o[k] = 1'b1;
            end
`ifdef MAC_LANE_RELU_EN
            if (r < 0) begin
                r = 0;
                e.o[k] = 1'b0;
            end
`endif
            e.d[k*W +: W] = r[W-1:0];
        end
        return e;
    endfunction

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(m_dout), 64'(0));
            end else begin
                chk("m_dout", 64'(m_dout), 64'(exp_q[0].d));
                chk("m_ovf", 64'(m_ovf), 64'(exp_q[0].o));
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive_beat(input int i, output bit ok);
        int tmo;
        bit rdy;
        s_valid = 1'b1;
        s_din   = W'(xb[i]);
        for (int k = 0; k < LANES; k++) s_w[k*W +: W] = W'(wb[i][k]);
        tmo = 0;
        do begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            tmo++;
        end while (!rdy && tmo < 50);
        ok = rdy;
        if (!rdy) chk("beat_timeout", 64'(0), 64'(1));
    endtask

    task automatic load_bias();
        for (int k = 0; k < LANES; k++) bias[k*W +: W] = W'(bb[k]);
    endtask

    // One complete pass; gap = idle cycles between beats, stall = m_ready low cycles
    task automatic run_pass(input int n, input int gap, input int stall);
        int nx;
        int waited;
        bit ok;
        bit v;
        exp_q.push_back(model(n));
        m_ready  = (stall == 0);
        load_bias();
        start    = 1'b1;
        n_inputs = CNT_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        nx = 0;
        for (int i = 0; i < n; i++) begin
            drive_beat(i, ok);
            if (!ok) break;
            nx++;
            if (gap > 0 && i < n - 1) begin
                s_valid  = 1'b0;
                s_din    = W'($urandom);
                start    = 1'b1;
                n_inputs = '0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                start    = 1'b0;
                n_inputs = CNT_W'(n);
            end
        end
        s_valid = 1'b0;
        chk("beats_accepted", 64'(nx), 64'(n));
        waited = 0;
        do begin
            @(negedge clk);
            v = m_valid;
            if (!v) begin
                if (waited == 0 && n > 0) chk("drain_s_ready", 64'(s_ready), 64'(0));
                waited++;
            end
        end while (!v && waited < 20);
        chk("latency", 64'(waited), 64'((n == 0) ? 0 : 1));
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk);
                #1;
                start    = 1'b1;
                n_inputs = CNT_W'($urandom_range(0, 3));
            end
            start   = 1'b0;
            m_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("m_valid_after_hs", 64'(m_valid), 64'(0));
        chk("busy_after_hs", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data(input int n);
        for (int k = 0; k < LANES; k++) bb[k] = int'($urandom_range(0, 4095)) - 2048;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < LANES; k++) begin
                xb[i]    = int'($urandom_range(0, 4095)) - 2048;
                wb[i][k] = int'($urandom_range(0, 4095)) - 2048;
            end
    endtask

    task automatic basic_data();
        rand_data(2);
        bb[0] = 64;   bb[1] = 64;
        xb[0] = 128;  xb[1] = 256;
        wb[0][0] = 64;   wb[1][0] = 32;
        wb[0][1] = -128; wb[1][1] = 128;
    endtask

    initial begin
        bit ok;
        int tmo;
        rst = 1'b1; start = 1'b0; n_inputs = '0; bias = '0;
        s_valid = 1'b0; s_din = '0; s_w = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_dout", 64'(m_dout), 64'(0));
        chk("rst_m_ovf", 64'(m_ovf), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        basic_data();
        run_pass(2, 0, 0);

        rand_data(1);
        for (int k = 0; k < LANES; k++) bb[k] = 0;
        xb[0] = 1; wb[0][0] = 64; wb[0][1] = 63;
        run_pass(1, 0, 0);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 2; i++) begin
                xb[i] = 1024;
                for (int k = 0; k < LANES; k++) wb[i][k] = (s == 0) ? 512 : -512;
            end
            for (int k = 0; k < LANES; k++) bb[k] = 0;
            run_pass(2, 0, 0);
        end

        rand_data(3);
        run_pass(3, 0, 0);
        run_pass(3, 2, 3);

        for (int k = 0; k < LANES; k++) bb[k] = -77;
        run_pass(0, 0, 0);

        for (int i = 0; i < 255; i++) begin
            xb[i] = -1;
            for (int k = 0; k < LANES; k++) wb[i][k] = -1;
        end
        for (int k = 0; k < LANES; k++) bb[k] = 0;
        run_pass(255, 0, 0);

        // Abort a pass after one of three beats
        rand_data(3);
        load_bias();
        start = 1'b1; n_inputs = CNT_W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        drive_beat(0, ok);
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", 64'(m_valid), 64'(0));
        chk("midrst_s_ready", 64'(s_ready), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        basic_data();
        run_pass(2, 0, 0);

        for (int p = 0; p < 15; p++) begin
            int n;
            n = int'($urandom_range(1, 16));
            rand_data(n);
            run_pass(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        tmo = 0;
        while (exp_q.size() != 0 && tmo < 100) begin
            @(posedge clk);
            tmo++;
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
